switch_allocator: RTL and testbench

- Separable input-first switch allocator for the router.
- Each cycle it matches per-VC switch requests from every input port to free output ports, using two arbiter stages:
  - Stage 1: per-input VC arbitration.
  - Stage 2: per-output input-port arbitration.
- Registered grants drive the crossbar select and the input-buffer read enables.
- Round-robin priorities advance only on final grants, so no requester starves.

---
 rtl/noc_params.sv | 17 +
 rtl/rr_arbiter_upd.sv | 47 ++++
 rtl/switch_allocator.sv | 158 +++++++++++++++
 tb/tb_switch_allocator.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_params.sv
// Shared router parameters: port/VC counts, derived index widths and port names.
package noc_params;

    localparam int PORT_NUM  = 5;
    localparam int VC_NUM    = 2;
    localparam int PORT_SIZE = $clog2(PORT_NUM);
    localparam int VC_SIZE   = $clog2(VC_NUM);

    typedef enum logic [PORT_SIZE-1:0] {
        LOCAL,
        NORTH,
        SOUTH,
        WEST,
        EAST
    } port_t;

endpackage

// File: rtl/rr_arbiter_upd.sv
// Round-robin arbiter with a combinational one-hot grant. The priority pointer
// moves one past the winner only when update_en is high, so a requester that
// wins here but loses further downstream keeps its priority.
module rr_arbiter_upd #(
    parameter int  AGENTS = 2,
    localparam int IDX_W  = (AGENTS > 1) ? $clog2(AGENTS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AGENTS-1:0] req,
    input  logic              update_en,
    output logic [AGENTS-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              gnt_valid
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand_idx;

    // Scan from the farthest candidate back to ptr so the nearest request wins.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand_idx  = '0;
        for (int k = AGENTS - 1; k >= 0; k--) begin
            cand_idx = IDX_W'((int'(ptr) + k) % AGENTS);
            if (req[cand_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
        if (gnt_valid) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Advance the priority pointer past the winner, wrapping at the last agent.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (update_en && gnt_valid) begin
            ptr <= (gnt_idx == IDX_W'(AGENTS - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator. Stage 1 picks one eligible VC per
// input, stage 2 picks one input per output; grants are registered.
// Optional packet locking of outputs is enabled by defining SA_PACKET_LOCK_EN.
module switch_allocator
    import noc_params::*;
(
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                request_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                credit_avail_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                tail_i,
    output logic [PORT_NUM-1:0]                            in_grant_o,
    output logic [PORT_NUM-1:0][VC_SIZE-1:0]               in_vc_sel_o,
    output logic [PORT_NUM-1:0]                            xbar_valid_o,
    output logic [PORT_NUM-1:0][PORT_SIZE-1:0]             xbar_sel_o
);

    logic [PORT_NUM-1:0][VC_NUM-1:0]    elig;
    logic [PORT_NUM-1:0][VC_NUM-1:0]    s1_req;
    logic [PORT_NUM-1:0][VC_NUM-1:0]    s1_gnt;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   s1_idx;
    logic [PORT_NUM-1:0]                s1_valid;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] tgt;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]  s2_req;   // [output][input]
    logic [PORT_NUM-1:0][PORT_NUM-1:0]  s2_gnt;   // [output][input]
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] s2_idx;
    logic [PORT_NUM-1:0]                s2_valid;
    logic [PORT_NUM-1:0]                fin_gnt;

    // A VC competes only with a flit, a downstream credit and a real output port.
    always_comb begin
        elig = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                elig[i][v] = request_i[i][v] & credit_avail_i[i][v] &
                             ({1'b0, out_port_i[i][v]} < (PORT_SIZE + 1)'(PORT_NUM));
            end
        end
    end

`ifdef SA_PACKET_LOCK_EN
    logic [PORT_NUM-1:0]                lock_valid;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] lock_in;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   lock_vc;
    logic [PORT_NUM-1:0][VC_NUM-1:0]    owns;
    logic [PORT_NUM-1:0][VC_NUM-1:0]    allowed;
    logic [PORT_NUM-1:0]                tail_w;

    // Mask requests to locked outputs from non-owners; an owning VC that is
    // eligible pre-empts the other VCs of its input.
    always_comb begin
        owns    = '0;
        allowed = elig;
        s1_req  = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                for (int o = 0; o < PORT_NUM; o++) begin
                    if (lock_valid[o] && lock_in[o] == PORT_SIZE'(i) &&
                        lock_vc[o] == VC_SIZE'(v)) begin
                        owns[i][v] = 1'b1;
                    end else if (lock_valid[o] && out_port_i[i][v] == PORT_SIZE'(o)) begin
                        allowed[i][v] = 1'b0;
                    end
                end
            end
            s1_req[i] = (|(allowed[i] & owns[i])) ? (allowed[i] & owns[i]) : allowed[i];
            tail_w[i] = |(tail_i[i] & s1_gnt[i]);
        end
    end

    // Lock an output on a non-tail grant; release when the owner sends its tail.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_valid <= '0;
            lock_in    <= '0;
            lock_vc    <= '0;
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if (s2_valid[o]) begin
                    lock_valid[o] <= !tail_w[s2_idx[o]];
                    lock_in[o]    <= s2_idx[o];
                    lock_vc[o]    <= s1_idx[s2_idx[o]];
                end else if (lock_valid[o] && fin_gnt[lock_in[o]] &&
                             s1_idx[lock_in[o]] == lock_vc[o] && tail_w[lock_in[o]]) begin
                    lock_valid[o] <= 1'b0;
                end
            end
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ^{tail_i, s1_gnt};
    assign s1_req      = elig;
`endif

    for (genvar i = 0; i < PORT_NUM; i++) begin : g_vc_arb
        rr_arbiter_upd #(.AGENTS(VC_NUM)) u_vc_arb (
            .clk       (clk),
            .rst       (rst),
            .req       (s1_req[i]),
            .update_en (fin_gnt[i]),
            .gnt       (s1_gnt[i]),
            .gnt_idx   (s1_idx[i]),
            .gnt_valid (s1_valid[i])
        );
    end

    // Route each stage-1 winner's request to the output its VC targets.
    always_comb begin
        tgt    = '0;
        s2_req = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            tgt[i] = out_port_i[i][s1_idx[i]];
            for (int o = 0; o < PORT_NUM; o++) begin
                s2_req[o][i] = s1_valid[i] && (tgt[i] == PORT_SIZE'(o));
            end
        end
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_port_arb
        rr_arbiter_upd #(.AGENTS(PORT_NUM)) u_port_arb (
            .clk       (clk),
            .rst       (rst),
            .req       (s2_req[o]),
            .update_en (s2_valid[o]),
            .gnt       (s2_gnt[o]),
            .gnt_idx   (s2_idx[o]),
            .gnt_valid (s2_valid[o])
        );
    end

    // An input is finally granted when it wins at the output it asked for.
    always_comb begin
        fin_gnt = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            fin_gnt = fin_gnt | s2_gnt[o];
        end
    end

    // Register the allocation; unused select fields are zeroed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_grant_o   <= '0;
            in_vc_sel_o  <= '0;
            xbar_valid_o <= '0;
            xbar_sel_o   <= '0;
        end else begin
            in_grant_o   <= fin_gnt;
            xbar_valid_o <= s2_valid;
            for (int i = 0; i < PORT_NUM; i++) begin
                in_vc_sel_o[i] <= fin_gnt[i] ? s1_idx[i] : '0;
                xbar_sel_o[i]  <= s2_valid[i] ? s2_idx[i] : '0;
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios plus random traffic checked by
// a scoreboard against a reference model of the allocation rules.
module tb_switch_allocator;
    import noc_params::*;

    localparam int P  = PORT_NUM;
    localparam int V  = VC_NUM;
    localparam int PS = PORT_SIZE;
    localparam int VS = VC_SIZE;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [P-1:0][V-1:0]         request_i, credit_avail_i, tail_i;
    logic [P-1:0][V-1:0][PS-1:0] out_port_i;
    logic [P-1:0]             in_grant_o, xbar_valid_o;
    logic [P-1:0][VS-1:0]     in_vc_sel_o;
    logic [P-1:0][PS-1:0]     xbar_sel_o;

    switch_allocator dut (
        .clk            (clk),
        .rst            (rst),
        .request_i      (request_i),
        .out_port_i     (out_port_i),
        .credit_avail_i (credit_avail_i),
        .tail_i         (tail_i),
        .in_grant_o     (in_grant_o),
        .in_vc_sel_o    (in_vc_sel_o),
        .xbar_valid_o   (xbar_valid_o),
        .xbar_sel_o     (xbar_sel_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [P-1:0]                g;
        logic [P-1:0][VS-1:0]        vs;
        logic [P-1:0]                xv;
        logic [P-1:0][PS-1:0]        xs;
        logic [P-1:0][V-1:0]         req;
        logic [P-1:0][V-1:0]         cr;
        logic [P-1:0][V-1:0][PS-1:0] port;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    int m_in_ptr[P];
    int m_out_ptr[P];
    bit m_lk[P];
    int m_lk_i[P];
    int m_lk_v[P];

    logic [P-1:0][V-1:0]         s_req, s_cr, s_tl;
    logic [P-1:0][V-1:0][PS-1:0] s_pt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the allocation rules to the current inputs.
    task automatic model_step(output exp_t e);
        bit elig[P][V];
        bit own[V];
        bit any_own;
        int win[P];
        int tgt_o[P];
        int winner[P];
        int v;
        int i;
        e = '{default: '0};
        e.req  = request_i;
        e.cr   = credit_avail_i;
        e.port = out_port_i;
        if (!rst) begin
            for (int k = 0; k < P; k++) begin
                m_in_ptr[k] = 0; m_out_ptr[k] = 0; m_lk[k] = 0; m_lk_i[k] = 0; m_lk_v[k] = 0;
            end
            return;
        end
        for (int a = 0; a < P; a++)
            for (int b = 0; b < V; b++)
                elig[a][b] = request_i[a][b] && credit_avail_i[a][b] && (int'(out_port_i[a][b]) < P);
`ifdef SA_PACKET_LOCK_EN
        for (int a = 0; a < P; a++) begin
            for (int b = 0; b < V; b++)
                for (int o = 0; o < P; o++)
                    if (m_lk[o] && int'(out_port_i[a][b]) == o && !(m_lk_i[o] == a && m_lk_v[o] == b))
                        elig[a][b] = 0;
            any_own = 0;
            for (int b = 0; b < V; b++) begin
                own[b] = 0;
                for (int o = 0; o < P; o++)
                    if (m_lk[o] && m_lk_i[o] == a && m_lk_v[o] == b) own[b] = 1;
                if (own[b] && elig[a][b]) any_own = 1;
            end
            if (any_own)
                for (int b = 0; b < V; b++) if (!own[b]) elig[a][b] = 0;
        end
`endif
        for (int a = 0; a < P; a++) begin
            win[a] = -1;
            for (int k = 0; k < V; k++) begin
                v = (m_in_ptr[a] + k) % V;
                if (win[a] < 0 && elig[a][v]) win[a] = v;
            end
            tgt_o[a] = (win[a] >= 0) ? int'(out_port_i[a][win[a]]) : -1;
        end
        for (int o = 0; o < P; o++) begin
            winner[o] = -1;
            for (int k = 0; k < P; k++) begin
                i = (m_out_ptr[o] + k) % P;
                if (winner[o] < 0 && win[i] >= 0 && tgt_o[i] == o) winner[o] = i;
            end
            if (winner[o] >= 0) begin
                e.xv[o] = 1'b1;
                e.xs[o] = PS'(winner[o]);
                e.g[winner[o]]  = 1'b1;
                e.vs[winner[o]] = VS'(win[winner[o]]);
                m_out_ptr[o] = (winner[o] + 1) % P;
                m_in_ptr[winner[o]] = (win[winner[o]] + 1) % V;
            end
        end
`ifdef SA_PACKET_LOCK_EN
        for (int o = 0; o < P; o++) begin
            if (winner[o] >= 0) begin
                m_lk[o]   = !tail_i[winner[o]][win[winner[o]]];
                m_lk_i[o] = winner[o];
                m_lk_v[o] = win[winner[o]];
            end else if (m_lk[o] && e.g[m_lk_i[o]] && win[m_lk_i[o]] == m_lk_v[o] &&
                         tail_i[m_lk_i[o]][m_lk_v[o]]) begin
                m_lk[o] = 0;
            end
        end
`endif
    endtask

    // Apply one cycle of stimulus, queue its expected response, then move on.
    task automatic drive(input logic r);
        exp_t e;
        rst            = r;
        request_i      = s_req;
        credit_avail_i = s_cr;
        tail_i         = s_tl;
        out_port_i     = s_pt;
        model_step(e);
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic clear_stim();
        s_req = '0; s_cr = '0; s_tl = '0; s_pt = '0;
    endtask

    task automatic do_reset();
        clear_stim();
        drive(1'b0);
    endtask

    // Monitor: compares every registered allocation against the scoreboard.
    initial begin : monitor
        exp_t e;
        logic [P-1:0][VS-1:0] act_vs, exp_vs;
        logic [P-1:0][PS-1:0] act_xs, exp_xs;
        bit inv_ok;
        int gi;
        int gv;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act_vs = '0; exp_vs = '0; act_xs = '0; exp_xs = '0;
                for (int k = 0; k < P; k++) begin
                    if (e.g[k])  begin act_vs[k] = in_vc_sel_o[k]; exp_vs[k] = e.vs[k]; end
                    if (e.xv[k]) begin act_xs[k] = xbar_sel_o[k];  exp_xs[k] = e.xs[k]; end
                end
                check("in_grant",   64'(in_grant_o),   64'(e.g));
                check("xbar_valid", 64'(xbar_valid_o), 64'(e.xv));
                check("in_vc_sel",  64'(act_vs),       64'(exp_vs));
                check("xbar_sel",   64'(act_xs),       64'(exp_xs));
                inv_ok = ($countones(in_grant_o) == $countones(xbar_valid_o));
                for (int o = 0; o < P; o++) begin
                    if (xbar_valid_o[o]) begin
                        gi = int'(xbar_sel_o[o]);
                        if (gi >= P) inv_ok = 0;
                        else if (!in_grant_o[gi]) inv_ok = 0;
                        else if (int'(e.port[gi][in_vc_sel_o[gi]]) != o) inv_ok = 0;
                    end
                end
                for (int k = 0; k < P; k++) begin
                    if (in_grant_o[k]) begin
                        gv = int'(in_vc_sel_o[k]);
                        if (gv >= V) inv_ok = 0;
                        else if (!(e.req[k][gv] && e.cr[k][gv])) inv_ok = 0;
                    end
                end
                check("invariants", 64'(inv_ok), 64'(1));
            end
        end
    end

    initial begin : stimulus
        int lock_exp[4];
`ifdef SA_PACKET_LOCK_EN
        lock_exp = '{1, 1, 1, 4};
`else
        lock_exp = '{1, 4, 1, 4};
`endif
        clear_stim();
        rst = 1'b0;
        request_i = '0; credit_avail_i = '0; tail_i = '0; out_port_i = '0;

        // Reset hold with every VC requesting its own port (U-turns).
        s_req = '1; s_cr = '1;
        for (int i = 0; i < P; i++) for (int v = 0; v < V; v++) s_pt[i][v] = PS'(i);
        drive(1'b0);
        drive(1'b0);
        check("rst_in_grant",   64'(in_grant_o),   64'(0));
        check("rst_xbar_valid", 64'(xbar_valid_o), 64'(0));
        drive(1'b1);
        check("first_grant_in0", 64'(in_grant_o[0]),  64'(1));
        check("first_grant_vc0", 64'(in_vc_sel_o[0]), 64'(0));

        // Conflict: inputs 1..3 VC0 all target output 4.
        do_reset();
        for (int i = 1; i <= 3; i++) begin s_req[i][0] = 1'b1; s_cr[i][0] = 1'b1; s_pt[i][0] = PS'(4); end
        for (int c = 0; c < 4; c++) begin
            drive(1'b1);
            check("conflict_sel4",  64'(xbar_sel_o[4]),          64'((c % 3) + 1));
            check("conflict_count", 64'($countones(in_grant_o)), 64'(1));
        end

        // VC fairness at input 2.
        do_reset();
        s_req[2] = '1; s_cr[2] = '1; s_pt[2][0] = PS'(0); s_pt[2][1] = PS'(1);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1);
            check("vc_fair_sel2", 64'(in_vc_sel_o[2]), 64'(c % 2));
        end

        // Credit gating on input 0 VC1.
        do_reset();
        s_req[0][1] = 1'b1; s_pt[0][1] = PS'(2);
        for (int c = 0; c < 5; c++) begin
            drive(1'b1);
            check("credit_blocked", 64'(in_grant_o[0]), 64'(0));
        end
        s_cr[0][1] = 1'b1;
        drive(1'b1);
        check("credit_granted", 64'(in_grant_o[0]),  64'(1));
        check("credit_vc",      64'(in_vc_sel_o[0]), 64'(1));

        // Full permutation: i -> (i+1) mod P.
        do_reset();
        for (int i = 0; i < P; i++) begin s_req[i][0] = 1'b1; s_cr[i][0] = 1'b1; s_pt[i][0] = PS'((i + 1) % P); end
        drive(1'b1);
        check("perm_in_grant",   64'(in_grant_o),   64'({P{1'b1}}));
        check("perm_xbar_valid", 64'(xbar_valid_o), 64'({P{1'b1}}));

        // Packet on input 1 to output 3 competing with input 4.
        do_reset();
        s_req[1][0] = 1'b1; s_cr[1][0] = 1'b1; s_pt[1][0] = PS'(3);
        s_req[4][0] = 1'b1; s_cr[4][0] = 1'b1; s_pt[4][0] = PS'(3);
        for (int c = 0; c < 4; c++) begin
            s_tl[1][0] = (c == 2);
            if (c == 3) s_req[1][0] = 1'b0;
            drive(1'b1);
            check("lock_sel3", 64'(xbar_sel_o[3]), 64'(lock_exp[c]));
        end

        // Random traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < P; i++) begin
                for (int v = 0; v < V; v++) begin
                    s_req[i][v] = ($urandom_range(0, 9) < 6);
                    s_cr[i][v]  = ($urandom_range(0, 9) < 8);
                    s_tl[i][v]  = ($urandom_range(0, 2) == 0);
                    s_pt[i][v]  = PS'($urandom_range(0, P));
                end
            end
            drive(($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1);
        end

        clear_stim();
        drive(1'b1);
        for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge clk);
        check("scoreboard_drain", 64'(sb_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
